ex_mem_stage: RTL

Execute-to-memory pipeline stage of the RV32 core. It captures each ALU result together with the instruction's writeback and memory controls, and buffers up to two entries so the memory stage can stall without creating a combinational ready path back into execute. It also merges the ALU's registered divide-by-zero flag into the matching entry as a trap bit.

---
 rtl/ex_mem_stage_pkg.sv | 38 +++
 rtl/ex_mem_stage_skid_fifo2.sv | 63 ++++++
 rtl/ex_mem_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared types and packing helpers for the execute-to-memory stage.
// Defines the control-bit struct and the field layout of the packed FIFO entry.
// No logic; imported by ex_mem_stage and its FIFO.
package ex_mem_stage_pkg;

  localparam int EXMEM_XLEN = 32;
  localparam int EXMEM_RW   = 5;

  // Control bits that travel with each result; packed LSB-first into the entry.
  typedef struct packed {
    logic zero;
    logic wb_en;
    logic mem_rd;
    logic mem_wr;
  } exmem_ctrl_t;

  localparam int EXMEM_CTRL_W = $bits(exmem_ctrl_t);

  // Entry layout (MSB..LSB): res | store_data | rd | ctrl
  function automatic int exmem_entry_w(input int xlen, input int rw);
    return 2 * xlen + rw + EXMEM_CTRL_W;
  endfunction

  function automatic int exmem_off_rd();
    return EXMEM_CTRL_W;
  endfunction

  function automatic int exmem_off_store(input int rw);
    return EXMEM_CTRL_W + rw;
  endfunction

  function automatic int exmem_off_res(input int xlen, input int rw);
    return EXMEM_CTRL_W + rw + xlen;
  endfunction

  localparam int EXMEM_ENTRY_W = exmem_entry_w(EXMEM_XLEN, EXMEM_RW);

endpackage

// File: rtl/ex_mem_stage_skid_fifo2.sv
// skid_fifo2: 2-entry FIFO with registered ready, decoupling execute from memory stalls.
// Latency: an entry written at edge N is visible at the head in cycle N+1.
// Backpressure: in_ready = (count != 2), from registered state only; flush empties it.
module skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             push_fire,
  output logic             head_idx,
  output logic             tail_idx
);

  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic             pop_fire;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[head];
  assign head_idx  = head;
  assign tail_idx  = tail;

  // A flush edge neither stores nor retires anything.
  assign push_fire = in_valid && in_ready && !flush;
  assign pop_fire  = out_valid && out_ready && !flush;

  // Pointer and occupancy bookkeeping; flush overrides push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push_fire) tail <= ~tail;
      if (pop_fire)  head <= ~head;
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push_fire) mem[tail] <= in_data;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM register stage, 2-deep buffered, with divide-by-zero trap merge (EXMEM_TRAP_EN).
// Latency: entry accepted at edge N is presented on out_* in cycle N+1.
// Backpressure: in_ready depends only on occupancy, never combinationally on out_ready.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int XLEN = EXMEM_XLEN,
  parameter int RW   = EXMEM_RW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_res,
  input  logic            in_zero,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [RW-1:0]   in_rd,
  input  logic            in_wb_en,
  input  logic            in_mem_rd,
  input  logic            in_mem_wr,
  input  logic            illegal_op,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic [XLEN-1:0] out_store_data,
  output logic [RW-1:0]   out_rd,
  output logic            out_zero,
  output logic            out_wb_en,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic            out_trap
);

  localparam int ENTRY_W   = exmem_entry_w(XLEN, RW);
  localparam int OFF_RD    = exmem_off_rd();
  localparam int OFF_STORE = exmem_off_store(RW);
  localparam int OFF_RES   = exmem_off_res(XLEN, RW);

  exmem_ctrl_t        in_ctrl;
  exmem_ctrl_t        head_ctrl;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               push_fire;
  logic               head_idx;
  logic               tail_idx;

  assign in_ctrl.zero   = in_zero;
  assign in_ctrl.wb_en  = in_wb_en;
  assign in_ctrl.mem_rd = in_mem_rd;
  assign in_ctrl.mem_wr = in_mem_wr;
  assign in_entry       = {in_res, in_store_data, in_rd, in_ctrl};

  skid_fifo2 #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_entry),
    .push_fire (push_fire),
    .head_idx  (head_idx),
    .tail_idx  (tail_idx)
  );

  assign head_ctrl      = head_entry[EXMEM_CTRL_W-1:0];
  assign out_res        = head_entry[OFF_RES +: XLEN];
  assign out_store_data = head_entry[OFF_STORE +: XLEN];
  assign out_rd         = head_entry[OFF_RD +: RW];
  assign out_zero       = head_ctrl.zero;
  assign out_wb_en      = head_ctrl.wb_en;
  assign out_mem_rd     = head_ctrl.mem_rd;
  assign out_mem_wr     = head_ctrl.mem_wr;

`ifdef EXMEM_TRAP_EN
  // trap/fresh live beside the FIFO, indexed by the same slot pointers, because
  // illegal_op arrives one cycle after its operands were accepted.
  logic [1:0] trap_q;
  logic [1:0] fresh_q;

  // Fold illegal_op into the entry pushed last edge, then mark the new push fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_q  <= 2'b00;
      fresh_q <= 2'b00;
    end else if (flush) begin
      trap_q  <= 2'b00;
      fresh_q <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fresh_q[i]) begin
          trap_q[i]  <= trap_q[i] | illegal_op;
          fresh_q[i] <= 1'b0;
        end
      end
      if (push_fire) begin
        trap_q[tail_idx]  <= 1'b0;
        fresh_q[tail_idx] <= 1'b1;
      end
    end
  end

  // A fresh head already reflects this cycle's flag without waiting for the merge edge.
  assign out_trap = trap_q[head_idx] | (fresh_q[head_idx] & illegal_op);
`else
  logic unused_trap_inputs;

  assign unused_trap_inputs = illegal_op ^ push_fire ^ head_idx ^ tail_idx;
  assign out_trap           = 1'b0;
`endif

endmodule
